// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data-cache controller between MEM stage and memory.
// Optional DCACHE_STAT_EN adds hit/miss counters (hit_cnt_o, miss_cnt_o).
module dcache_controller #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INDEX_W = 5,
    parameter int unsigned LINE_W  = 256
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              p1_req_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
`ifdef DCACHE_STAT_EN
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o,
`endif
    input  logic              mem_ack_i
);

    localparam int unsigned OFFSET_W = 5;
    localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned LINES    = 2 ** INDEX_W;

    typedef enum logic [1:0] {StIdle, StWriteback, StRefill} stateT;

    stateT              stateQ;
    logic [LINES-1:0]   validQ;
    logic [LINES-1:0]   dirtyQ;
    logic [TAG_W-1:0]   missTagQ;
    logic [TAG_W-1:0]   tagArr  [LINES];
    logic [LINE_W-1:0]  lineArr [LINES];

    logic [TAG_W-1:0]   reqTag;
    logic [INDEX_W-1:0] reqIndex;
    logic [2:0]         reqWord;
    logic [INDEX_W-1:0] fillIndex;
    logic [TAG_W-1:0]   fillTag;
    logic [LINE_W-1:0]  curLine;
    logic               hit;
    logic               idleHit;
    logic               missStart;
    logic               unusedByteBits;

    assign reqTag         = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign reqIndex       = p1_addr_i[OFFSET_W +: INDEX_W];
    assign reqWord        = p1_addr_i[4:2];
    assign unusedByteBits = ^p1_addr_i[1:0];

    // While a miss is outstanding the registered memory address names the line being moved
    assign fillIndex = mem_addr_o[OFFSET_W +: INDEX_W];
    assign fillTag   = mem_addr_o[ADDR_W-1 -: TAG_W];

    assign curLine   = lineArr[reqIndex];
    assign hit       = p1_req_i & validQ[reqIndex] & (tagArr[reqIndex] == reqTag);
    assign idleHit   = (stateQ == StIdle) & hit;
    assign missStart = (stateQ == StIdle) & p1_req_i & ~hit;

    assign p1_stall_o = p1_req_i & ~idleHit;
    assign p1_data_o  = (idleHit & ~p1_write_i) ? curLine[{reqWord, 5'b0} +: 32] : 32'h0;

    // Tag and line storage carry no reset; valid bits guard them
    always_ff @(posedge clk_i) begin
        if (stateQ == StRefill && mem_ack_i) begin
            lineArr[fillIndex] <= mem_data_i;
            tagArr[fillIndex]  <= fillTag;
        end else if (idleHit && p1_write_i) begin
            lineArr[reqIndex][{reqWord, 5'b0} +: 32] <= p1_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stateQ       <= StIdle;
            validQ       <= '0;
            dirtyQ       <= '0;
            missTagQ     <= '0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            case (stateQ)
                StIdle: begin
                    if (idleHit && p1_write_i) begin
                        dirtyQ[reqIndex] <= 1'b1;
                    end
                    if (missStart) begin
                        missTagQ     <= reqTag;
                        mem_enable_o <= 1'b1;
                        if (validQ[reqIndex] && dirtyQ[reqIndex]) begin
                            stateQ      <= StWriteback;
                            mem_write_o <= 1'b1;
                            mem_addr_o  <= {tagArr[reqIndex], reqIndex, 5'b0};
                            mem_data_o  <= curLine;
                        end else begin
                            stateQ      <= StRefill;
                            mem_write_o <= 1'b0;
                            mem_addr_o  <= {reqTag, reqIndex, 5'b0};
                        end
                    end
                end
                StWriteback: begin
                    if (mem_ack_i) begin
                        stateQ      <= StRefill;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {missTagQ, fillIndex, 5'b0};
                    end
                end
                StRefill: begin
                    if (mem_ack_i) begin
                        stateQ            <= StIdle;
                        mem_enable_o      <= 1'b0;
                        validQ[fillIndex] <= 1'b1;
                        dirtyQ[fillIndex] <= 1'b0;
                    end
                end
                default: stateQ <= StIdle;
            endcase
        end
    end

`ifdef DCACHE_STAT_EN
    logic        retryQ;
    logic [31:0] hitCntQ;
    logic [31:0] missCntQ;

    // retryQ marks the single IDLE cycle following a refill so the retried access is not a hit
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            retryQ   <= 1'b0;
            hitCntQ  <= '0;
            missCntQ <= '0;
        end else begin
            if (stateQ == StRefill && mem_ack_i) begin
                retryQ <= 1'b1;
            end else if (stateQ == StIdle) begin
                retryQ <= 1'b0;
            end
            if (idleHit && !retryQ) begin
                hitCntQ <= hitCntQ + 32'd1;
            end
            if (missStart) begin
                missCntQ <= missCntQ + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hitCntQ;
    assign miss_cnt_o = missCntQ;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: memory responder, programmer-view memory model and cache-residency
// model; define DCACHE_STAT_EN to also check the statistics counters.
module tb_dcache_controller;

    logic         clk;
    logic         rstN;
    logic         p1Req;
    logic         p1Write;
    logic [31:0]  p1Addr;
    logic [31:0]  p1DataIn;
    logic [31:0]  p1DataOut;
    logic         p1Stall;
    logic         memEnable;
    logic         memWrite;
    logic [31:0]  memAddr;
    logic [255:0] memDataOut;
    logic [255:0] memDataIn;
    logic         memAck;
`ifdef DCACHE_STAT_EN
    logic [31:0]  hitCnt;
    logic [31:0]  missCnt;
`endif

    dcache_controller dut (
        .clk_i        (clk),
        .rst_n_i      (rstN),
        .p1_req_i     (p1Req),
        .p1_write_i   (p1Write),
        .p1_addr_i    (p1Addr),
        .p1_data_i    (p1DataIn),
        .p1_data_o    (p1DataOut),
        .p1_stall_o   (p1Stall),
        .mem_enable_o (memEnable),
        .mem_write_o  (memWrite),
        .mem_addr_o   (memAddr),
        .mem_data_o   (memDataOut),
        .mem_data_i   (memDataIn),
`ifdef DCACHE_STAT_EN
        .hit_cnt_o    (hitCnt),
        .miss_cnt_o   (missCnt),
`endif
        .mem_ack_i    (memAck)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks;
    int errors;

    // Programmer-visible memory and the memory device's own contents
    logic [31:0] golden  [logic [31:0]];
    logic [31:0] backing [logic [31:0]];
    // Which line each direct-mapped slot holds
    logic [31:0] mLine   [32];
    bit          mValid  [32];
    bit          mDirty  [32];

    int           lat;
    bit           autoAck;
    logic         manualAck;
    int           ackCount;
    int           respCnt;
    logic [31:0]  lastFetch;
    logic [31:0]  lastWb;
    logic [255:0] lastWbLine;

    function automatic logic [31:0] initVal(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] goldRd(input logic [31:0] a);
        return golden.exists(a) ? golden[a] : initVal(a);
    endfunction

    function automatic logic [31:0] backRd(input logic [31:0] a);
        return backing.exists(a) ? backing[a] : initVal(a);
    endfunction

    function automatic logic [255:0] goldLine(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = goldRd(la + 32'(w * 4));
        return l;
    endfunction

    function automatic logic [255:0] backLine(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = backRd(la + 32'(w * 4));
        return l;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory device: acks lat cycles after the phase's first enable cycle, one pulse per phase
    initial begin
        memAck    = 1'b0;
        memDataIn = '0;
        respCnt   = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!rstN) begin
                memAck  = 1'b0;
                respCnt = 0;
            end else if (!autoAck) begin
                memAck  = manualAck;
                respCnt = 0;
            end else if (memAck) begin
                memAck  = 1'b0;
                respCnt = memEnable ? 1 : 0;
            end else if (memEnable) begin
                respCnt++;
                if (respCnt == lat + 1) begin
                    memAck = 1'b1;
                    ackCount++;
                    if (memWrite) begin
                        lastWb     = memAddr;
                        lastWbLine = memDataOut;
                        for (int w = 0; w < 8; w++)
                            backing[memAddr + 32'(w * 4)] = memDataOut[w*32 +: 32];
                    end else begin
                        lastFetch = memAddr;
                        memDataIn = backLine(memAddr);
                    end
                end
            end
            if (!memAck) begin
                for (int w = 0; w < 8; w++) memDataIn[w*32 +: 32] = $urandom();
            end
        end
    end

    // One pipeline access; every cycle is compared against the expected miss timeline
    task automatic doAccess(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input int l, output int stallCnt, output logic [31:0] rdata);
        logic [31:0]  lineA;
        logic [31:0]  victimA;
        logic [255:0] victimL;
        int           idx;
        int           s;
        int           acks0;
        bit           miss;
        bit           dirtyMiss;
        lineA     = {addr[31:5], 5'b0};
        idx       = int'(addr[9:5]);
        miss      = !(mValid[idx] && mLine[idx] == lineA);
        dirtyMiss = miss && mValid[idx] && mDirty[idx];
        victimA   = mLine[idx];
        victimL   = mValid[idx] ? goldLine(victimA) : '0;
        s         = !miss ? 0 : (dirtyMiss ? 2 * l + 3 : l + 2);
        lat       = l;
        acks0     = ackCount;
        stallCnt  = 0;
        rdata     = '0;
        p1Req     = 1'b1;
        p1Write   = wr;
        p1Addr    = addr;
        p1DataIn  = wr ? wdata : $urandom();
        for (int c = 0; c <= s; c++) begin
            bit          expEn;
            bit          expWr;
            logic [31:0] expAddr;
            @(negedge clk);
            if (p1Stall) stallCnt++;
            chk("stall", p1Stall, c < s);
            expEn   = 1'b0;
            expWr   = 1'b0;
            expAddr = '0;
            if (dirtyMiss && c >= 1 && c <= l + 1) begin
                expEn = 1'b1; expWr = 1'b1; expAddr = victimA;
            end else if (dirtyMiss && c >= l + 2 && c <= 2 * l + 2) begin
                expEn = 1'b1; expAddr = lineA;
            end else if (miss && !dirtyMiss && c >= 1 && c <= l + 1) begin
                expEn = 1'b1; expAddr = lineA;
            end
            chk("mem_enable", memEnable, expEn);
            if (expEn) begin
                chk("mem_write", memWrite, expWr);
                chk("mem_addr", memAddr, expAddr);
                if (expWr) chk("mem_wb_data", memDataOut, victimL);
            end
            if (!wr) begin
                if (c == s) begin
                    rdata = p1DataOut;
                    chk("load_data", p1DataOut, goldRd(addr));
                end else begin
                    chk("load_data_idle_zero", p1DataOut, 32'h0);
                end
            end
            @(posedge clk);
            #1;
        end
        chk("acks_per_access", ackCount - acks0, miss ? (dirtyMiss ? 2 : 1) : 0);
        p1Req = 1'b0;
        if (miss) begin
            mValid[idx] = 1'b1;
            mLine[idx]  = lineA;
            mDirty[idx] = 1'b0;
        end
        if (wr) begin
            golden[addr] = wdata;
            mDirty[idx]  = 1'b1;
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_stall", p1Stall, 1'b0);
            chk("idle_mem_enable", memEnable, 1'b0);
        end
        @(posedge clk);
        #1;
    endtask

    int          sc;
    logic [31:0] rd;

    initial begin
        checks    = 0;
        errors    = 0;
        ackCount  = 0;
        lat       = 10;
        autoAck   = 1'b1;
        manualAck = 1'b0;
        lastFetch = '0;
        lastWb    = '0;
        lastWbLine = '0;
        rstN      = 1'b0;
        p1Req     = 1'b0;
        p1Write   = 1'b0;
        p1Addr    = '0;
        p1DataIn  = '0;
        for (int i = 0; i < 32; i++) begin
            mLine[i] = '0; mValid[i] = 1'b0; mDirty[i] = 1'b0;
        end

        #12;
        chk("reset_stall", p1Stall, 1'b0);
        chk("reset_mem_enable", memEnable, 1'b0);
        chk("reset_mem_write", memWrite, 1'b0);
        chk("reset_mem_addr", memAddr, 32'h0);
        chk("reset_mem_data", memDataOut, 256'h0);
        chk("reset_p1_data", p1DataOut, 32'h0);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        // Cold load, ack 10 cycles after enable
        doAccess(1'b0, 32'h0000_0040, 32'h0, 10, sc, rd);
        chk("s1_stall_cycles", sc, 12);
        chk("s1_data", rd, 32'h5A5A_0040);
        chk("s1_fetch_addr", lastFetch, 32'h0000_0040);

        doAccess(1'b0, 32'h0000_0044, 32'h0, 10, sc, rd);
        chk("s2_stall_cycles", sc, 0);
        chk("s2_data", rd, 32'h5A5A_0044);

        // Store hit dirties the line, then a conflicting load forces write-back
        doAccess(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 10, sc, rd);
        chk("s3_store_stall", sc, 0);
        doAccess(1'b0, 32'h0000_0440, 32'h0, 10, sc, rd);
        chk("s3_stall_cycles", sc, 23);
        chk("s3_wb_addr", lastWb, 32'h0000_0040);
        chk("s3_wb_word0", lastWbLine[31:0], 32'hDEAD_BEEF);
        chk("s3_wb_word1", lastWbLine[63:32], 32'h5A5A_0044);
        chk("s3_fetch_addr", lastFetch, 32'h0000_0440);
        chk("s3_data", rd, 32'h5A5A_0440);
`ifdef DCACHE_STAT_EN
        chk("stat_miss_cnt", missCnt, 32'd2);
        chk("stat_hit_cnt", hitCnt, 32'd2);
`endif
        // Refilled line must be clean: a further eviction needs no write-back
        doAccess(1'b0, 32'h0000_0840, 32'h0, 10, sc, rd);
        chk("s3_clean_evict_stall", sc, 12);

        // Slow memory, both a clean store-miss and a dirty load-miss
        doAccess(1'b1, 32'h1234_5660, 32'hCAFE_F00D, 50, sc, rd);
        chk("s4_store_miss_stall", sc, 52);
        doAccess(1'b0, 32'h0000_0660, 32'h0, 50, sc, rd);
        chk("s4_dirty_miss_stall", sc, 103);
        chk("s4_wb_addr", lastWb, 32'h1234_5660);
        chk("s4_wb_word0", lastWbLine[31:0], 32'hCAFE_F00D);
        chk("s4_data", rd, 32'h5A5A_0660);

        // Reset in the middle of a refill, stale ack afterwards
        autoAck = 1'b0;
        p1Req   = 1'b1;
        p1Write = 1'b0;
        p1Addr  = 32'h0000_0880;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("s5_refill_enable", memEnable, 1'b1);
        chk("s5_refill_addr", memAddr, 32'h0000_0880);
        chk("s5_refill_write", memWrite, 1'b0);
        #1;
        rstN = 1'b0;
        #1;
        chk("s5_rst_enable", memEnable, 1'b0);
        chk("s5_rst_addr", memAddr, 32'h0);
        p1Req = 1'b0;
        #1;
        chk("s5_rst_stall", p1Stall, 1'b0);
        chk("s5_rst_p1_data", p1DataOut, 32'h0);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        manualAck = 1'b1;
        @(posedge clk);
        #1;
        manualAck = 1'b0;
        idleCycles(4);
        for (int i = 0; i < 32; i++) begin
            mValid[i] = 1'b0; mDirty[i] = 1'b0;
        end
        golden.delete();
        foreach (backing[k]) golden[k] = backing[k];
        autoAck = 1'b1;

        doAccess(1'b0, 32'h0000_0880, 32'h0, 5, sc, rd);
        chk("s5_remiss_stall", sc, 7);
        chk("s5_remiss_data", rd, 32'h5A5A_0880);
        doAccess(1'b0, 32'h0000_0040, 32'h0, 10, sc, rd);
        chk("s5_written_back_data", rd, 32'hDEAD_BEEF);
        chk("s5_written_back_stall", sc, 12);
        idleCycles(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
